// File: rtl/spi_target.sv
// SPI mode-0 responder: oversamples controller CS/SCK/MOSI on FastClk, deserialises
// MSB-first bytes into a small RX FIFO and shifts a single-entry TX holding byte out on MISO.
module spi_target #(
    parameter int unsigned RX_DEPTH = 4,
    parameter logic        IDLE_DO  = 1'b1
) (
    input  logic       FastClk,
    input  logic       nReset,
    input  logic       SPI_Cs,
    input  logic       SPI_Clk,
    input  logic       SPI_Di,
    output logic       SPI_Do,
    output logic       SPI_DoEn,
    input  logic [7:0] TxData,
    input  logic       TxValid,
    output logic       TxReady,
    output logic [7:0] RxData,
    output logic       RxValid,
    input  logic       RxReady,
    output logic       Selected,
    output logic       Overrun,
    output logic       Underrun,
    input  logic       ClearFlags
);

    localparam int unsigned AW = $clog2(RX_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t      r_state, w_state_nxt;

    logic        r_cs_meta, r_cs_sync, r_cs_dly;
    logic        r_sck_meta, r_sck_sync, r_sck_dly;
    logic        r_di_meta, r_di_sync;

    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_rx_shift;
    logic [7:0]  r_tx_shift;
    logic [7:0]  r_hold;
    logic        r_hold_full;
    logic        r_do;
    logic        r_overrun, r_underrun;

    logic [7:0]  r_mem [RX_DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;

    logic        w_cs_fall, w_cs_rise, w_sck_rise, w_sck_fall;
    logic        w_start, w_stop, w_rise_act, w_fall_act;
    logic        w_tx_load, w_tx_accept, w_unr_set;
    logic [7:0]  w_rx_byte;
    logic        w_push_req, w_push, w_pop, w_empty, w_full, w_ovr_set;

    // Synchronisers reset low so a CS already low at reset release never looks like a falling edge.
    always_ff @(posedge FastClk or negedge nReset) begin
        if (!nReset) begin
            r_cs_meta  <= 1'b0;
            r_cs_sync  <= 1'b0;
            r_cs_dly   <= 1'b0;
            r_sck_meta <= 1'b0;
            r_sck_sync <= 1'b0;
            r_sck_dly  <= 1'b0;
            r_di_meta  <= 1'b0;
            r_di_sync  <= 1'b0;
        end else begin
            r_cs_meta  <= SPI_Cs;
            r_cs_sync  <= r_cs_meta;
            r_cs_dly   <= r_cs_sync;
            r_sck_meta <= SPI_Clk;
            r_sck_sync <= r_sck_meta;
            r_sck_dly  <= r_sck_sync;
            r_di_meta  <= SPI_Di;
            r_di_sync  <= r_di_meta;
        end
    end

    assign w_cs_fall  = r_cs_dly & ~r_cs_sync;
    assign w_cs_rise  = ~r_cs_dly & r_cs_sync;
    assign w_sck_rise = ~r_sck_dly & r_sck_sync;
    assign w_sck_fall = r_sck_dly & ~r_sck_sync;

    always_ff @(posedge FastClk or negedge nReset) begin
        if (!nReset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_stop      = 1'b0;
        w_rise_act  = 1'b0;
        w_fall_act  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = ST_ACTIVE;
                    w_start     = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_stop      = 1'b1;
                end else begin
                    w_rise_act = w_sck_rise;
                    w_fall_act = w_sck_fall;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_tx_load   = w_start | (w_fall_act & (r_bit_cnt == 3'd0));
    assign w_tx_accept = TxValid & ~r_hold_full;
    assign w_unr_set   = w_tx_load & ~r_hold_full;

    // A load with the holding register empty underruns even if a byte is accepted that same cycle.
    always_ff @(posedge FastClk or negedge nReset) begin
        if (!nReset) begin
            r_tx_shift  <= '1;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_tx_load && r_hold_full) begin
            r_tx_shift  <= r_hold;
            r_hold_full <= 1'b0;
        end else begin
            if (w_tx_load)       r_tx_shift <= 8'hFF;
            else if (w_fall_act) r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            if (w_tx_accept) begin
                r_hold      <= TxData;
                r_hold_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge FastClk or negedge nReset) begin
        if (!nReset) r_do <= IDLE_DO;
        else         r_do <= (r_state == ST_ACTIVE && !w_stop) ? r_tx_shift[7] : IDLE_DO;
    end

    assign w_rx_byte  = {r_rx_shift[6:0], r_di_sync};
    assign w_push_req = w_rise_act & (r_bit_cnt == 3'd7);

    always_ff @(posedge FastClk or negedge nReset) begin
        if (!nReset) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
        end else if (w_start || w_stop) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
        end else if (w_rise_act) begin
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            r_rx_shift <= w_rx_byte;
        end
    end

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop     = ~w_empty & RxReady;
    assign w_push    = w_push_req & (~w_full | w_pop);
    assign w_ovr_set = w_push_req & w_full & ~w_pop;

    always_ff @(posedge FastClk or negedge nReset) begin
        if (!nReset) begin
            for (int unsigned i = 0; i < RX_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= w_rx_byte;
                r_wr_ptr                <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge FastClk or negedge nReset) begin
        if (!nReset) begin
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_overrun  <= w_ovr_set | (r_overrun & ~ClearFlags);
            r_underrun <= w_unr_set | (r_underrun & ~ClearFlags);
        end
    end

    assign SPI_Do   = r_do;
    assign SPI_DoEn = (r_state == ST_ACTIVE);
    assign Selected = (r_state == ST_ACTIVE);
    assign TxReady  = ~r_hold_full;
    assign RxData   = r_mem[r_rd_ptr[AW-1:0]];
    assign RxValid  = ~w_empty;
    assign Overrun  = r_overrun;
    assign Underrun = r_underrun;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: drives a mode-0 controller at FastClk/16 and checks MISO bytes,
// FIFO contents and sticky flags against a queue-based model of the link.
module tb_spi_target;

    localparam int DEPTH = 4;

    logic       FastClk = 1'b0;
    logic       nReset, SPI_Cs, SPI_Clk, SPI_Di;
    logic       SPI_Do, SPI_DoEn, TxReady, RxValid, Selected, Overrun, Underrun;
    logic [7:0] TxData, RxData;
    logic       TxValid, RxReady, ClearFlags;

    always #5 FastClk = ~FastClk;

    spi_target #(.RX_DEPTH(DEPTH), .IDLE_DO(1'b1)) dut (
        .FastClk(FastClk), .nReset(nReset), .SPI_Cs(SPI_Cs), .SPI_Clk(SPI_Clk),
        .SPI_Di(SPI_Di), .SPI_Do(SPI_Do), .SPI_DoEn(SPI_DoEn), .TxData(TxData),
        .TxValid(TxValid), .TxReady(TxReady), .RxData(RxData), .RxValid(RxValid),
        .RxReady(RxReady), .Selected(Selected), .Overrun(Overrun), .Underrun(Underrun),
        .ClearFlags(ClearFlags)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] rx_q[$];
    logic [7:0] hold_q[$];
    bit         m_ovr = 1'b0;
    bit         m_unr = 1'b0;
    logic [7:0] mosi_a [8];
    logic [7:0] dummy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] next_tx();
        if (hold_q.size() > 0) return hold_q.pop_front();
        m_unr = 1'b1;
        return 8'hFF;
    endfunction

    function automatic void model_push(input logic [7:0] b);
        if (rx_q.size() < DEPTH) rx_q.push_back(b);
        else                     m_ovr = 1'b1;
    endfunction

    task automatic preload(input logic [7:0] b);
        check("txready_empty", TxReady, 1'b1);
        TxData  = b;
        TxValid = 1'b1;
        @(negedge FastClk);
        TxValid = 1'b0;
        check("txready_full", TxReady, 1'b0);
        hold_q.push_back(b);
    endtask

    task automatic pop_one(input string tag);
        check({tag, "_valid"}, RxValid, rx_q.size() > 0);
        if (rx_q.size() > 0) begin
            check({tag, "_data"}, RxData, rx_q[0]);
            RxReady = 1'b1;
            @(negedge FastClk);
            RxReady = 1'b0;
            dummy = rx_q.pop_front();
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_overrun"}, Overrun, m_ovr);
        check({tag, "_underrun"}, Underrun, m_unr);
    endtask

    task automatic clear_flags();
        ClearFlags = 1'b1;
        @(negedge FastClk);
        ClearFlags = 1'b0;
        m_ovr = 1'b0;
        m_unr = 1'b0;
    endtask

    // Final bit of a frame drops SCK and raises CS together, so no trailing byte-boundary reload.
    task automatic send_bits(input logic [7:0] mosi, input int nbits, input bit last,
                             input bit pop_here, output logic [7:0] miso);
        miso = '0;
        for (int i = 0; i < nbits; i++) begin
            SPI_Di = mosi[7-i];
            repeat (8) @(negedge FastClk);
            miso[7-i] = SPI_Do;
            SPI_Clk = 1'b1;
            if (pop_here && i == 7 && rx_q.size() > 0) begin
                repeat (2) @(negedge FastClk);
                check("pop_on_push_data", RxData, rx_q[0]);
                RxReady = 1'b1;
                @(negedge FastClk);
                RxReady = 1'b0;
                dummy = rx_q.pop_front();
                repeat (5) @(negedge FastClk);
            end else begin
                repeat (8) @(negedge FastClk);
            end
            SPI_Clk = 1'b0;
            if (last && i == nbits - 1) SPI_Cs = 1'b1;
        end
        if (last) repeat (8) @(negedge FastClk);
    endtask

    task automatic transfer(input int n, input bit pop_last, input string tag);
        logic [7:0] exp_miso, miso;
        SPI_Cs = 1'b0;
        repeat (8) @(negedge FastClk);
        for (int k = 0; k < n; k++) begin
            exp_miso = next_tx();
            send_bits(mosi_a[k], 8, k == n - 1, pop_last && k == n - 1, miso);
            check($sformatf("%s_miso%0d", tag, k), miso, exp_miso);
            model_push(mosi_a[k]);
        end
        check({tag, "_deselected"}, Selected, 1'b0);
        check({tag, "_do_idle"}, SPI_Do, 1'b1);
    endtask

    initial begin
        logic [7:0] miso;
        int         n;
        nReset = 1'b0; SPI_Cs = 1'b1; SPI_Clk = 1'b0; SPI_Di = 1'b0;
        TxData = '0; TxValid = 1'b0; RxReady = 1'b0; ClearFlags = 1'b0;
        repeat (3) @(negedge FastClk);
        check("rst_do", SPI_Do, 1'b1);
        check("rst_doen", SPI_DoEn, 1'b0);
        check("rst_selected", Selected, 1'b0);
        check("rst_txready", TxReady, 1'b1);
        check("rst_rxvalid", RxValid, 1'b0);
        check("rst_rxdata", RxData, 8'h00);
        check_flags("rst");
        nReset = 1'b1;
        repeat (4) @(negedge FastClk);

        // Preloaded byte out, 3C in
        preload(8'hA5);
        mosi_a[0] = 8'h3C;
        transfer(1, 1'b0, "t1");
        check_flags("t1");
        pop_one("t1_pop");
        pop_one("t1_empty");

        // Empty TX: three underrun bytes
        mosi_a[0] = 8'h01; mosi_a[1] = 8'h02; mosi_a[2] = 8'h03;
        transfer(3, 1'b0, "t2");
        check_flags("t2");
        for (int i = 0; i < 4; i++) pop_one("t2_pop");

        // Five bytes into a four-deep FIFO
        for (int i = 0; i < 5; i++) mosi_a[i] = 8'h10 + 8'(i);
        transfer(5, 1'b0, "t3");
        check_flags("t3");
        for (int i = 0; i < 5; i++) pop_one("t3_pop");
        clear_flags();
        check_flags("t3_clear");

        // Abort after five bits
        SPI_Cs = 1'b0;
        repeat (8) @(negedge FastClk);
        dummy = next_tx();
        send_bits(8'hF0, 5, 1'b1, 1'b0, miso);
        check("t4_selected", Selected, 1'b0);
        check("t4_do_idle", SPI_Do, 1'b1);
        check("t4_no_push", RxValid, 1'b0);
        mosi_a[0] = 8'h55;
        transfer(1, 1'b0, "t4");
        pop_one("t4_pop");
        check_flags("t4");

        // Reset mid-transfer with CS held low through release
        SPI_Cs = 1'b0;
        repeat (8) @(negedge FastClk);
        dummy = next_tx();
        send_bits(8'($urandom), 3, 1'b0, 1'b0, miso);
        nReset = 1'b0;
        #1;
        rx_q.delete(); hold_q.delete(); m_ovr = 1'b0; m_unr = 1'b0;
        check("t5_rst_selected", Selected, 1'b0);
        check("t5_rst_do", SPI_Do, 1'b1);
        check("t5_rst_txready", TxReady, 1'b1);
        check_flags("t5_rst");
        @(negedge FastClk);
        nReset = 1'b1;
        repeat (4) @(negedge FastClk);
        for (int i = 0; i < 8; i++) begin
            SPI_Di = 1'($urandom);
            SPI_Clk = 1'b1;
            repeat (8) @(negedge FastClk);
            SPI_Clk = 1'b0;
            repeat (8) @(negedge FastClk);
        end
        check("t5_doen", SPI_DoEn, 1'b0);
        check("t5_no_push", RxValid, 1'b0);
        SPI_Cs = 1'b1;
        repeat (8) @(negedge FastClk);
        mosi_a[0] = 8'h99;
        transfer(1, 1'b0, "t5");
        pop_one("t5_pop");
        check_flags("t5");

        // Fifth byte lands in the same cycle as a pop on a full FIFO
        clear_flags();
        for (int i = 0; i < 5; i++) mosi_a[i] = 8'($urandom);
        transfer(5, 1'b1, "t6");
        check_flags("t6");
        for (int i = 0; i < 5; i++) pop_one("t6_pop");

        // Randomised transfers
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) preload(8'($urandom));
            for (int k = 0; k < n; k++) mosi_a[k] = 8'($urandom);
            transfer(n, 1'b0, $sformatf("rnd%0d", r));
            check_flags($sformatf("rnd%0d", r));
            for (int p = $urandom_range(0, 2); p > 0; p--) pop_one("rnd_pop");
            if ($urandom_range(0, 3) == 0) clear_flags();
        end
        for (int i = 0; i < DEPTH + 1; i++) pop_one("drain_pop");
        check_flags("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
